// File: rtl/insn_fetch_unit.sv
// Fetch stage sitting between the PC and a 1-cycle-latency instruction memory.
// It issues sequential reads, pairs each returned word with its address and
// queues the pair in a small valid/ready FIFO for decode. Redirects flush
// everything queued or in flight. Halt stops new reads but lets the queue drain.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   imem_ra       memory read address (registered PC)
//   imem_rd       memory read data, valid one cycle after imem_ra is sampled
//   halt          stop issuing new reads
//   redirect_vld  load PC from redirect_pc and flush
//   redirect_pc   redirect target
//   out_vld       FIFO head holds an instruction
//   out_rdy       decode accepts the head entry
//   out_insn      instruction word at the FIFO head
//   out_pc        address out_insn was fetched from
module insn_fetch_unit #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned LAST_ADDR  = 254,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_ra,
  input  logic [DATA_W-1:0] imem_rd,
  input  logic              halt,
  input  logic              redirect_vld,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_insn,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OccW = CntW + 1;

  localparam logic [ADDR_W-1:0] ResetPc  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(LAST_ADDR);
  localparam logic [PtrW-1:0]   PtrMax   = PtrW'(FIFO_DEPTH - 1);
  localparam logic [CntW-1:0]   CntMax   = CntW'(FIFO_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;

  logic [DATA_W-1:0] insn_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] epc_q  [FIFO_DEPTH];

  logic              pop;
  logic              push;
  logic              issue;
  logic [OccW-1:0]   occ;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrMax) ? '0 : p + 1'b1;
  endfunction

  assign imem_ra  = pc_q;
  assign out_vld  = (count_q != '0);
  assign out_insn = insn_q[head_q];
  assign out_pc   = epc_q[head_q];

  assign pop  = out_vld && out_rdy;
  // A redirect kills the word returning this cycle, so it is never captured.
  assign push = inflight_q && !redirect_vld;

  // Credits: entries held plus the read in flight, less the slot freed by a
  // pop this cycle. Pop implies count >= 1, so this never underflows.
  assign occ   = OccW'(count_q) + OccW'(inflight_q) - OccW'(pop);
  assign issue = !halt && !redirect_vld && (occ < OccW'(CntMax));

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;

    if (redirect_vld) begin
      pc_d    = redirect_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = (pc_q == LastAddr) ? '0 : pc_q + 1'b1;
      end
      if (push) begin
        tail_d = ptr_inc(tail_q);
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= ResetPc;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        insn_q[i] <= '0;
        epc_q[i]  <= '0;
      end
    end else if (push) begin
      insn_q[tail_q] <= imem_rd;
      epc_q[tail_q]  <= inflight_pc_q;
    end
  end

  // The credit rule must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == CntMax)));

endmodule

// File: tb/tb_insn_fetch_unit.sv
module tb_insn_fetch_unit;

  localparam int unsigned LastAddr = 254;

  logic        clk;
  logic        rst_n;
  logic [7:0]  imem_ra;
  logic [15:0] imem_rd;
  logic        halt;
  logic        redirect_vld;
  logic [7:0]  redirect_pc;
  logic        out_vld;
  logic        out_rdy;
  logic [15:0] out_insn;
  logic [7:0]  out_pc;

  int checks;
  int failures;
  int pops;

  insn_fetch_unit #(
    .ADDR_W    (8),
    .DATA_W    (16),
    .RESET_PC  (0),
    .LAST_ADDR (LastAddr),
    .FIFO_DEPTH(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_ra     (imem_ra),
    .imem_rd     (imem_rd),
    .halt        (halt),
    .redirect_vld(redirect_vld),
    .redirect_pc (redirect_pc),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .out_insn    (out_insn),
    .out_pc      (out_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: upper byte is the address XOR 0x5A, lower byte the address.
  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  function automatic logic [7:0] next_pc(input logic [7:0] p);
    return (p == 8'(LastAddr)) ? 8'd0 : p + 8'd1;
  endfunction

  // 1-cycle-latency synchronous read memory.
  initial imem_rd = '0;
  always @(posedge clk) imem_rd <= mem_word(imem_ra);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream model: every accepted word must be the next sequential address
  // (with wrap) and carry that address's memory word; a redirect restarts the
  // sequence at its target and empties the output in the following cycle.
  logic [7:0] exp_pc;
  logic       redir_prev;
  initial begin
    exp_pc     = 8'd0;
    redir_prev = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc     = 8'd0;
      redir_prev = 1'b0;
      check("reset_out_vld", 32'(out_vld), 32'd0);
      check("reset_imem_ra", 32'(imem_ra), 32'd0);
    end else begin
      if (redir_prev) check("flush_out_vld", 32'(out_vld), 32'd0);
      if (out_vld && out_rdy) begin
        check("stream_pc", 32'(out_pc), 32'(exp_pc));
        check("stream_insn", 32'(out_insn), 32'(mem_word(exp_pc)));
        exp_pc = next_pc(exp_pc);
        pops++;
      end
      if (redirect_vld) exp_pc = redirect_pc;
      redir_prev = redirect_vld;
    end
  end

  logic [7:0] held_ra;
  bit         seen;

  initial begin
    checks       = 0;
    failures     = 0;
    pops         = 0;
    rst_n        = 1'b0;
    halt         = 1'b0;
    redirect_vld = 1'b0;
    redirect_pc  = 8'd0;
    out_rdy      = 1'b1;

    // Reset values
    tick();
    tick();
    check("rst_out_insn", 32'(out_insn), 32'd0);
    check("rst_out_pc", 32'(out_pc), 32'd0);
    check("rst_vld", 32'(out_vld), 32'd0);

    // 1: release, first word two cycles after first issue
    rst_n = 1'b1;
    tick();
    check("t1_vld_c1", 32'(out_vld), 32'd0);
    tick();
    check("t1_vld_c2", 32'(out_vld), 32'd1);
    check("t1_pc0", 32'(out_pc), 32'h00);
    check("t1_insn0", 32'(out_insn), 32'h5A00);
    tick();
    check("t1_insn1", 32'(out_insn), 32'h5B01);
    tick();
    check("t1_insn2", 32'(out_insn), 32'h5802);
    tick();
    check("t1_pc3", 32'(out_pc), 32'h03);
    check("t1_insn3", 32'(out_insn), 32'h5903);

    // 2: decode stalls for 6 cycles; reads stop once the queue is full
    out_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t2_ra_hold", 32'(imem_ra), 32'h05);
    end
    check("t2_head_pc", 32'(out_pc), 32'h03);
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_no_gap", 32'(out_vld), 32'd1);
      check("t2_order", 32'(out_pc), 32'(3 + i));
      tick();
    end

    // 3: fill queue, then redirect to 0x40 with a simultaneous pop
    out_rdy = 1'b0;
    tick();
    tick();
    out_rdy      = 1'b1;
    redirect_vld = 1'b1;
    redirect_pc  = 8'h40;
    tick();
    redirect_vld = 1'b0;
    check("t3_vld_r1", 32'(out_vld), 32'd0);
    tick();
    check("t3_vld_r2", 32'(out_vld), 32'd0);
    tick();
    check("t3_vld_r3", 32'(out_vld), 32'd1);
    check("t3_pc", 32'(out_pc), 32'h40);
    check("t3_insn", 32'(out_insn), 32'h1A40);

    // 4: redirect while streaming (word in flight is dropped), then wrap
    tick();
    redirect_vld = 1'b1;
    redirect_pc  = 8'd253;
    tick();
    redirect_vld = 1'b0;
    tick();
    tick();
    check("t4_pc253", 32'(out_pc), 32'd253);
    check("t4_insn253", 32'(out_insn), 32'hA7FD);
    tick();
    check("t4_pc254", 32'(out_pc), 32'd254);
    check("t4_insn254", 32'(out_insn), 32'hA4FE);
    tick();
    check("t4_pc0", 32'(out_pc), 32'd0);
    check("t4_insn0", 32'(out_insn), 32'h5A00);
    tick();
    check("t4_pc1", 32'(out_pc), 32'd1);
    check("t4_vld", 32'(out_vld), 32'd1);

    // 5: halt for 5 cycles, queue drains, resume without loss or repeat
    halt    = 1'b1;
    held_ra = imem_ra;
    check("t5_ra_start", 32'(held_ra), 32'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_ra_hold", 32'(imem_ra), 32'(held_ra));
    end
    check("t5_drained", 32'(out_vld), 32'd0);
    halt = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = out_vld;
    end
    check("t5_resume_seen", 32'(seen), 32'd1);
    check("t5_resume_pc", 32'(out_pc), 32'(held_ra));

    // 7: redirect beyond LAST_ADDR is taken as given and wraps naturally
    redirect_vld = 1'b1;
    redirect_pc  = 8'd255;
    tick();
    redirect_vld = 1'b0;
    tick();
    tick();
    check("t7_pc255", 32'(out_pc), 32'd255);
    check("t7_insn255", 32'(out_insn), 32'hA5FF);
    tick();
    check("t7_pc0", 32'(out_pc), 32'd0);

    // 6: asynchronous reset mid-stream
    tick();
    check("t6_pre_vld", 32'(out_vld), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_vld", 32'(out_vld), 32'd0);
    check("t6_async_ra", 32'(imem_ra), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_vld_c1", 32'(out_vld), 32'd0);
    tick();
    check("t6_vld_c2", 32'(out_vld), 32'd1);
    check("t6_pc0", 32'(out_pc), 32'd0);
    check("t6_insn0", 32'(out_insn), 32'h5A00);
    for (int i = 0; i < 4; i++) tick();

    check("total_pops_nonzero", 32'(pops > 20), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
